mem_arbiter: RTL

Two-port to one-port memory arbiter that shares the core's single synchronous memory between the instruction-fetch requester and the load/store requester. It sits between the core pipeline and the memory array. It sequences each access through a three-state FSM and applies fixed data-over-fetch priority, with an optional anti-starvation guard for fetch.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_starve_cnt.sv | 32 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared state and grant encodings for mem_arbiter and its starvation guard.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_t;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// arb_starve_cnt: counts data grants made while fetch waits and raises a force-fetch flag.
// Present only when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arb,
  input  logic i_gnt_d,
  input  logic i_ireq,
  output logic o_force
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_cnt;

  // Every IDLE edge either bumps the count (data won over a waiting fetch) or clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_arb) begin
      if (i_gnt_d && i_ireq) r_cnt <= r_cnt + 1'b1;
      else                   r_cnt <= '0;
    end
  end

  assign o_force = (r_cnt == CW'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: data-over-fetch priority, IDLE/ACCESS/RESP sequencing.
// Optional fetch anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  arb_state_t r_state;
  arb_gnt_t   r_gnt;
  logic       r_dwe;
  logic       w_force;
  logic       w_pick_d;

`ifdef ARB_STARVE_GUARD_EN
  logic w_idle;
  assign w_idle = (r_state == IDLE);

  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_arb   (w_idle),
    .i_gnt_d (w_pick_d),
    .i_ireq  (i_req),
    .o_force (w_force)
  );
`else
  // Constant 0; the comparison only keeps STARVE_MAX referenced in the unguarded build.
  assign w_force = (STARVE_MAX != STARVE_MAX);
`endif

  assign w_pick_d = d_req && !(w_force && i_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_gnt     <= GNT_I;
      r_dwe     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          if (i_req || d_req) begin
            r_state <= ACCESS;
            mem_en  <= 1'b1;
            if (w_pick_d) begin
              r_gnt     <= GNT_D;
              r_dwe     <= d_we;
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              r_gnt     <= GNT_I;
              r_dwe     <= 1'b0;
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          r_state <= RESP;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          i_ack   <= (r_gnt == GNT_I);
          d_ack   <= (r_gnt == GNT_D);
        end
        RESP: begin
          r_state <= IDLE;
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          i_ack   <= 1'b0;
          d_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign i_rdata = i_ack ? mem_rdata : '0;
  assign d_rdata = (d_ack && !r_dwe) ? mem_rdata : '0;

endmodule
